regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for a two-port (ALU / load) register file with a
// round-robin grant, one-cycle registered write port and a pending-write scoreboard.
module regfile_wb_arbiter (
   input  logic        clk,
   input  logic        reset,
   input  logic        a_valid,
   input  logic [4:0]  a_rd,
   input  logic [31:0] a_data,
   output logic        a_ready,
   input  logic        b_valid,
   input  logic [4:0]  b_rd,
   input  logic [31:0] b_data,
   output logic        b_ready,
   input  logic        iss_valid,
   input  logic [4:0]  iss_rd,
   output logic        iss_ready,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   output logic        stall_rs1,
   output logic        stall_rs2,
   output logic        we,
   output logic [4:0]  rd,
   output logic [31:0] wdata,
   output logic [31:0] pending
);

   typedef enum logic {
      SEL_A = 1'b0,
      SEL_B = 1'b1
   } sel_e;

   sel_e        rr_q, rr_d;
   logic        we_q, we_d;
   logic [4:0]  rd_q, rd_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] pending_q, pending_d;

   // Grant: the round-robin pointer only arbitrates, and only moves, under contention.
   always_comb begin
      a_ready = 1'b0;
      b_ready = 1'b0;
      rr_d    = rr_q;
      if (!reset) begin
         if (a_valid && b_valid) begin
            if (rr_q == SEL_A) begin
               a_ready = 1'b1;
               rr_d    = SEL_B;
            end else begin
               b_ready = 1'b1;
               rr_d    = SEL_A;
            end
         end else begin
            a_ready = a_valid;
            b_ready = b_valid;
         end
      end
   end

   always_comb begin
      we_d    = 1'b0;
      rd_d    = rd_q;
      wdata_d = wdata_q;
      if (a_valid && a_ready) begin
         rd_d    = a_rd;
         wdata_d = a_data;
         we_d    = (a_rd != '0);
      end else if (b_valid && b_ready) begin
         rd_d    = b_rd;
         wdata_d = b_data;
         we_d    = (b_rd != '0);
      end
   end

   assign iss_ready = !pending_q[iss_rd] && !reset;

   // Clear first so a same-index set on the same edge wins.
   always_comb begin
      pending_d = pending_q;
      if (we_q) begin
         pending_d[rd_q] = 1'b0;
      end
      if (iss_valid && iss_ready && (iss_rd != '0)) begin
         pending_d[iss_rd] = 1'b1;
      end
   end

   assign stall_rs1 = pending_q[rs1] && (rs1 != '0);
   assign stall_rs2 = pending_q[rs2] && (rs2 != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_q      <= SEL_A;
         we_q      <= 1'b0;
         rd_q      <= '0;
         wdata_q   <= '0;
         pending_q <= '0;
      end else begin
         rr_q      <= rr_d;
         we_q      <= we_d;
         rd_q      <= rd_d;
         wdata_q   <= wdata_d;
         pending_q <= pending_d;
      end
   end

   assign we      = we_q;
   assign rd      = rd_q;
   assign wdata   = wdata_q;
   assign pending = pending_q;

endmodule
